// File: rtl/uart_rx_fsm.sv
// Frame-sequencing controller for the UART receiver: walks start/data/parity/stop,
// strobes the sampler, deserializer and checkers, and reports frame status.
module uart_rx_fsm #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_in,
    input  logic                      par_en,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [3:0]                bit_cnt,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic                      cnt_en,
    output logic                      dat_samp_en,
    output logic                      deser_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      data_valid,
    output logic                      par_error,
    output logic                      stop_error,
    output logic                      busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e state_q, state_d;
    logic   data_valid_q, data_valid_d;
    logic   par_error_q, par_error_d;
    logic   stop_error_q, stop_error_d;

    logic [PRESCALE_WIDTH-1:0] chk_edge;
    logic [PRESCALE_WIDTH-1:0] last_edge;
    logic                      at_chk;
    logic                      bit_end;

    // The sampler votes over the three edges around mid-bit, so its result
    // settles two edges past the midpoint.
    assign chk_edge  = (prescale >> 1) + PRESCALE_WIDTH'(2);
    assign last_edge = prescale - PRESCALE_WIDTH'(1);
    assign at_chk    = (edge_cnt == chk_edge);
    assign bit_end   = (edge_cnt == last_edge);

    assign busy        = (state_q != IDLE);
    assign cnt_en      = busy;
    assign dat_samp_en = busy;
    assign strt_chk_en = (state_q == START)  && at_chk;
    assign deser_en    = (state_q == DATA)   && at_chk;
    assign par_chk_en  = (state_q == PARITY) && at_chk;
    assign stp_chk_en  = (state_q == STOP)   && at_chk;

    assign data_valid = data_valid_q;
    assign par_error  = par_error_q;
    assign stop_error = stop_error_q;

    always_comb begin
        state_d      = state_q;
        data_valid_d = 1'b0;
        par_error_d  = par_error_q;
        stop_error_d = stop_error_q;
        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d      = START;
                    par_error_d  = 1'b0;
                    stop_error_d = 1'b0;
                end
            end
            START: begin
                if (strt_chk_en && strt_glitch) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == 4'd8)) begin
                    state_d = par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (par_chk_en && par_err) begin
                    par_error_d = 1'b1;
                    state_d     = IDLE;
                end else if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave at the check edge rather than the bit end so a
                // back-to-back start edge is never missed.
                if (stp_chk_en) begin
                    state_d = IDLE;
                    if (stp_err) begin
                        stop_error_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            data_valid_q <= 1'b0;
            par_error_q  <= 1'b0;
            stop_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_valid_q <= data_valid_d;
            par_error_q  <= par_error_d;
            stop_error_q <= stop_error_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: models the edge/bit counter and deserializer, drives
// serial frames and scores each frame's strobes, timing and status flags.
module tb_uart_rx_fsm;

    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          par_en;
    logic [PW-1:0] prescale;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic          cnt_en, dat_samp_en, deser_en;
    logic          strt_chk_en, par_chk_en, stp_chk_en;
    logic          data_valid, par_error, stop_error, busy;

    uart_rx_fsm #(.PRESCALE_WIDTH(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .par_en      (par_en),
        .prescale    (prescale),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .cnt_en      (cnt_en),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .par_error   (par_error),
        .stop_error  (stop_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int valid;
        int perr;
        int serr;
        int n_deser;
        int n_strt;
        int n_par;
        int n_stp;
        int strt_idx;
        int first_deser;
        int span;
        int stp_idx;
        int end_idx;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         dv_total = 0;
    int         dv_exp = 0;
    int         idle_viol = 0;
    logic [7:0] shreg;

    // Edge/bit counter and deserializer the FSM would normally drive.
    always @(posedge clk) begin
        if (!cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == prescale - 6'd1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    always @(posedge clk) begin
        if (deser_en) shreg <= {rx_in, shreg[7:1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where busy is seen low.
    task automatic send_frame(input logic [7:0] data, input int glitch, input int abort_bit);
        int         p;
        int         chk;
        int         nb;
        int         limit;
        int         bi;
        logic [3:0] bi4;
        logic [10:0] bits;
        exp_t       e;
        p     = int'(prescale);
        chk   = p / 2 + 2;
        nb    = par_en ? 11 : 10;
        limit = 12 * p + 20;
        bits  = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        if (par_en) bits[9] = ^data;

        e.data = data; e.valid = 0; e.perr = 0; e.serr = 0;
        e.n_deser = 8; e.n_strt = 1; e.n_par = 0; e.n_stp = 0;
        e.strt_idx = chk; e.first_deser = p + chk; e.span = 7 * p;
        e.stp_idx = -1; e.end_idx = -1;
        if (glitch != 0) begin
            e.n_deser = 0;
            e.end_idx = chk + 1;
        end else if (abort_bit > 0) begin
            e.n_deser = abort_bit - 1;
        end else if (par_en && par_err) begin
            e.n_par = 1; e.perr = 1;
            e.end_idx = 9 * p + chk + 1;
        end else begin
            e.n_par   = par_en ? 1 : 0;
            e.n_stp   = 1;
            e.stp_idx = (par_en ? 10 : 9) * p + chk;
            e.end_idx = e.stp_idx + 1;
            e.serr    = stp_err ? 1 : 0;
            e.valid   = stp_err ? 0 : 1;
        end
        sb_q.push_back(e);
        if (e.valid != 0) dv_exp++;

        for (int c = 0; c < limit; c++) begin
            if (glitch != 0) begin
                rx_in = (c < 2) ? 1'b0 : 1'b1;
            end else begin
                bi = c / p;
                bi4 = 4'(bi);
                rx_in = (bi < nb) ? bits[bi4] : 1'b1;
            end
            @(negedge clk);
            if (c == 0) begin
                check("flags_clr_par", 32'(par_error), 32'd0);
                check("flags_clr_stop", 32'(stop_error), 32'd0);
            end
            if (abort_bit > 0 && c == abort_bit * p + 1) begin
                #2 rst = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_strobes", 32'({cnt_en, dat_samp_en, deser_en,
                                          strt_chk_en, par_chk_en, stp_chk_en}), 32'd0);
                check("rst_flags", 32'({data_valid, par_error, stop_error}), 32'd0);
                rx_in = 1'b1;
                @(negedge clk);
                rst = 1'b1;
                break;
            end
            if (!busy) break;
        end
        rx_in = 1'b1;
        check("frame_end", 32'(busy), 32'd0);
    endtask

    // Per-frame monitor: tracks cycle index since START entry and scores on busy fall.
    initial begin
        int   idx = 0;
        int   nd = 0, ns = 0, np = 0, nst = 0;
        int   strt_i = -1, first_d = -1, last_d = -1, stp_i = -1;
        logic prev_busy = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                idx = 0; nd = 0; ns = 0; np = 0; nst = 0;
                strt_i = -1; first_d = -1; last_d = -1; stp_i = -1;
            end else if (busy || prev_busy) begin
                idx++;
            end
            if (busy) begin
                if (strt_chk_en) begin ns++; strt_i = idx; end
                if (deser_en) begin
                    if (nd == 0) first_d = idx;
                    last_d = idx;
                    nd++;
                end
                if (par_chk_en) np++;
                if (stp_chk_en) begin nst++; stp_i = idx; end
            end else if (cnt_en || dat_samp_en || deser_en || strt_chk_en || par_chk_en || stp_chk_en) begin
                idle_viol++;
            end
            if (data_valid) dv_total++;
            if (!busy && prev_busy) begin
                check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("data_valid", 32'(data_valid), 32'(e.valid));
                    check("par_error", 32'(par_error), 32'(e.perr));
                    check("stop_error", 32'(stop_error), 32'(e.serr));
                    check("n_deser", 32'(nd), 32'(e.n_deser));
                    check("n_strt_chk", 32'(ns), 32'(e.n_strt));
                    check("n_par_chk", 32'(np), 32'(e.n_par));
                    check("n_stp_chk", 32'(nst), 32'(e.n_stp));
                    check("strt_idx", 32'(strt_i), 32'(e.strt_idx));
                    if (e.end_idx >= 0) check("end_idx", 32'(idx), 32'(e.end_idx));
                    if (e.stp_idx >= 0) check("stp_idx", 32'(stp_i), 32'(e.stp_idx));
                    if (e.n_deser == 8) begin
                        check("first_deser", 32'(first_d), 32'(e.first_deser));
                        check("deser_span", 32'(last_d - first_d), 32'(e.span));
                    end
                    if (e.valid != 0) check("byte", 32'(shreg), 32'(e.data));
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 500000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;

        #2 rst = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_strobes", 32'({cnt_en, dat_samp_en, deser_en,
                                    strt_chk_en, par_chk_en, stp_chk_en}), 32'd0);
        check("reset_flags", 32'({data_valid, par_error, stop_error}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(20);
        check("idle_after_reset", 32'({busy, cnt_en}), 32'd0);

        // Clean frame, 8x oversampling, no parity.
        send_frame(8'hA5, 0, 0);
        idle(5);

        // Start-bit glitch.
        strt_glitch = 1'b1;
        send_frame(8'h00, 1, 0);
        strt_glitch = 1'b0;
        idle(5);

        // Parity error at 16x, then a clean frame clears the flag.
        prescale = 6'd16; par_en = 1'b1; par_err = 1'b1;
        send_frame(8'h3C, 0, 0);
        par_err = 1'b0;
        idle(3);
        send_frame(8'h5A, 0, 0);
        idle(5);

        // Framing error at 32x.
        prescale = 6'd32; par_en = 1'b0; stp_err = 1'b1;
        send_frame(8'hC3, 0, 0);
        stp_err = 1'b0;
        idle(5);

        // Back-to-back frames one cycle after the IDLE return.
        prescale = 6'd16; par_en = 1'b1;
        send_frame(8'h81, 0, 0);
        send_frame(8'h7E, 0, 0);
        idle(5);

        // Reset during data bit 4, then a clean frame.
        send_frame(8'h96, 0, 4);
        idle(5);
        check("idle_after_abort", 32'({busy, cnt_en}), 32'd0);
        send_frame(8'h69, 0, 0);
        idle(10);

        check("dv_total", 32'(dv_total), 32'(dv_exp));
        check("idle_strobe_viol", 32'(idle_viol), 32'd0);
        check("sb_left", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
